// File: rtl/saturn_pkg.sv
// Shared types and constants for the Saturn data-memory transfer path.
package saturn_pkg;

  localparam int unsigned SATURN_ADDR_W = 20;
  localparam int unsigned SATURN_NIBS   = 16;

  // Nibble index within a register image.
  typedef logic [3:0] nib_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } xfer_state_t;

endpackage

// File: rtl/saturn_dmem_xfer.sv
// Nibble-serial DAT0/DAT1 register<->memory mover. Walks the nibble field
// right_mask..left_mask over the 4-bit bus, one nibble per acknowledged cycle.
module saturn_dmem_xfer
  import saturn_pkg::*;
#(
  parameter int unsigned ADDR_W = SATURN_ADDR_W,
  parameter int unsigned NIBS   = SATURN_NIBS
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                start_read_in,
  input  logic                start_write_in,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [4*NIBS-1:0]   data_in,
  input  logic [3:0]          right_mask_in,
  input  logic [3:0]          left_mask_in,
  output logic [4*NIBS-1:0]   data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic                bus_rd_o,
  output logic                bus_wr_o,
  output logic [3:0]          bus_data_o,
  input  logic [3:0]          bus_data_in,
  input  logic                bus_ack_in
);

  xfer_state_t           state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [4*NIBS-1:0]     wdata_q;
  logic [4*NIBS-1:0]     data_q;
  nib_idx_t              idx_q;
  nib_idx_t              left_q;
  logic                  write_q;
  // Inverted field: spend one XFER cycle with strobes off, then report DONE.
  logic                  illegal_q;

  logic                  start;
  logic                  field_bad;
  logic                  active;
  logic                  last_nib;
  logic [3:0]            wr_nib;

  assign start     = start_read_in | start_write_in;
  assign field_bad = left_mask_in < right_mask_in;
  assign active    = (state_q == XFER) && !illegal_q;
  assign last_nib  = idx_q == left_q;

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an unacknowledged nibble simply holds XFER.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (illegal_q) begin
          state_d = DONE;
        end else if (bus_ack_in && last_nib) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer context and read-image assembly.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      left_q    <= '0;
      write_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        addr_q    <= addr_in;
        wdata_q   <= data_in;
        idx_q     <= right_mask_in;
        left_q    <= left_mask_in;
        write_q   <= start_write_in;  // write wins over a simultaneous read
        illegal_q <= field_bad;
        // A legal read starts from a clean image; writes never touch it.
        if (!start_write_in && !field_bad) begin
          data_q <= '0;
        end
      end
    end else if (active && bus_ack_in) begin
      if (!write_q) begin
        for (int i = 0; i < NIBS; i++) begin
          if (idx_q == nib_idx_t'(i)) begin
            data_q[i*4 +: 4] <= bus_data_in;
          end
        end
      end
      addr_q <= addr_q + ADDR_W'(1);
      idx_q  <= idx_q + nib_idx_t'(1);
    end
  end

  // Write-nibble mux over the latched register image.
  always_comb begin
    wr_nib = '0;
    for (int i = 0; i < NIBS; i++) begin
      if (idx_q == nib_idx_t'(i)) begin
        wr_nib = wdata_q[i*4 +: 4];
      end
    end
  end

  // Outputs decoded from state so reset drops strobes without waiting for an edge.
  always_comb begin
    busy_o     = state_q == XFER;
    done_o     = state_q == DONE;
    bus_rd_o   = active && !write_q;
    bus_wr_o   = active && write_q;
    bus_addr_o = addr_q;
    bus_data_o = (active && write_q) ? wr_nib : 4'h0;
    data_o     = data_q;
  end

endmodule

// File: tb/tb_saturn_dmem_xfer.sv
// Bench for saturn_dmem_xfer: transaction-level model plus directed and random stimulus.
module tb_saturn_dmem_xfer;

  localparam int ADDR_W = 20;
  localparam int NIBS   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_read = 1'b0;
  logic              start_write = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [63:0]       data_in = '0;
  logic [3:0]        right_mask = '0;
  logic [3:0]        left_mask = '0;
  logic [63:0]       data_o;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rd;
  logic              bus_wr;
  logic [3:0]        bus_data_out;
  logic [3:0]        bus_data_in = '0;
  logic              bus_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  saturn_dmem_xfer #(.ADDR_W(ADDR_W), .NIBS(NIBS)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .start_read_in  (start_read),
    .start_write_in (start_write),
    .addr_in        (addr),
    .data_in        (data_in),
    .right_mask_in  (right_mask),
    .left_mask_in   (left_mask),
    .data_o         (data_o),
    .busy_o         (busy),
    .done_o         (done),
    .bus_addr_o     (bus_addr),
    .bus_rd_o       (bus_rd),
    .bus_wr_o       (bus_wr),
    .bus_data_o     (bus_data_out),
    .bus_data_in    (bus_data_in),
    .bus_ack_in     (bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 moving nibbles, 2 inverted-field wait, 3 done.
  int          m_phase;
  logic        m_write;
  logic [19:0] m_base;
  logic [63:0] m_word;
  logic [63:0] m_data;
  int          m_r, m_l, m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_data  <= '0;
      m_cnt   <= 0;
      m_write <= 1'b0;
    end else begin
      case (m_phase)
        0: if (start_write || start_read) begin
          m_write <= start_write;
          m_base  <= addr;
          m_word  <= data_in;
          m_r     <= int'(right_mask);
          m_l     <= int'(left_mask);
          m_cnt   <= 0;
          if (left_mask < right_mask) m_phase <= 2;
          else begin
            m_phase <= 1;
            if (!start_write) m_data <= '0;
          end
        end
        1: if (bus_ack) begin
          if (!m_write) m_data[(m_r + m_cnt)*4 +: 4] <= bus_data_in;
          m_cnt <= m_cnt + 1;
          if (m_r + m_cnt == m_l) m_phase <= 3;
        end
        2: m_phase <= 3;
        default: m_phase <= 0;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [19:0] ea;
      ea = m_base + 20'(m_cnt);
      chk("busy", 64'(busy), 64'(m_phase == 1 || m_phase == 2));
      chk("done", 64'(done), 64'(m_phase == 3));
      chk("rd", 64'(bus_rd), 64'(m_phase == 1 && !m_write));
      chk("wr", 64'(bus_wr), 64'(m_phase == 1 && m_write));
      chk("data_o", data_o, m_data);
      if (m_phase == 1) chk("bus_addr", 64'(bus_addr), 64'(ea));
      if (m_phase == 1 && m_write) chk("bus_data", 64'(bus_data_out), 64'(m_word[(m_r + m_cnt)*4 +: 4]));
      else chk("bus_data_idle", 64'(bus_data_out), 64'h0);
    end
  end

  task automatic issue(input logic w, input logic r, input logic [19:0] a, input logic [63:0] d,
                       input logic [3:0] rm, input logic [3:0] lm);
    @(posedge clk); #1;
    start_write = w; start_read = r; addr = a; data_in = d; right_mask = rm; left_mask = lm;
    @(posedge clk); #1;
    start_write = 1'b0; start_read = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[16];
    int ret[5];
    seq = '{1, 15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
    ret = '{3, 2, 1, 0, 15};

    #3;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_rd", 64'(bus_rd), 64'h0);
    chk("rst_wr", 64'(bus_wr), 64'h0);
    chk("rst_bus_data", 64'(bus_data_out), 64'h0);
    chk("rst_bus_addr", 64'(bus_addr), 64'h0);
    chk("rst_data_o", data_o, 64'h0);
    #9 rst_n = 1'b1;

    // 16-nibble write, ack tied high.
    bus_ack = 1'b1;
    issue(1'b1, 1'b0, 20'h80000, 64'h123456789ABCDEF1, 4'd0, 4'd15);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i < 16) begin
        chk("t1_wr", 64'(bus_wr), 64'h1);
        chk("t1_addr", 64'(bus_addr), 64'(20'h80000 + 20'(i)));
        chk("t1_nib", 64'(bus_data_out), 64'(seq[i]));
        chk("t1_done_early", 64'(done), 64'h0);
      end else begin
        chk("t1_done", 64'(done), 64'h1);
        chk("t1_wr_off", 64'(bus_wr), 64'h0);
      end
      if (i < 16) begin @(posedge clk); #1; end
    end

    // 5-nibble read.
    issue(1'b0, 1'b1, 20'h00100, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 4'd4);
    for (int i = 0; i < 5; i++) begin
      bus_data_in = 4'(ret[i]);
      @(negedge clk);
      chk("t2_busy", 64'(busy), 64'h1);
      chk("t2_rd", 64'(bus_rd), 64'h1);
      chk("t2_addr", 64'(bus_addr), 64'(20'h00100 + 20'(i)));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t2_done", 64'(done), 64'h1);
    chk("t2_data", data_o, 64'h00000000000F0123);

    // Address wrap.
    issue(1'b0, 1'b1, 20'hFFFFF, 64'h0, 4'd2, 4'd3);
    bus_data_in = 4'h7;
    @(negedge clk);
    chk("t3_addr0", 64'(bus_addr), 64'hFFFFF);
    @(posedge clk); #1;
    bus_data_in = 4'h8;
    @(negedge clk);
    chk("t3_addr1", 64'(bus_addr), 64'h00000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_done", 64'(done), 64'h1);
    chk("t3_data", data_o, 64'h0000000000008700);

    // Inverted field: no strobes, done at N+2, read image untouched.
    issue(1'b0, 1'b1, 20'h00400, 64'h0, 4'd3, 4'd1);
    @(negedge clk);
    chk("t6c_rd", 64'(bus_rd), 64'h0);
    chk("t6c_done_early", 64'(done), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6c_done", 64'(done), 64'h1);
    chk("t6c_data", data_o, 64'h0000000000008700);

    // Wait states on the first nibble of a 2-nibble write.
    bus_ack = 1'b0;
    issue(1'b1, 1'b0, 20'h01230, 64'h00000000000000C5, 4'd0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_wr", 64'(bus_wr), 64'h1);
      chk("t4_addr", 64'(bus_addr), 64'h01230);
      chk("t4_nib", 64'(bus_data_out), 64'h5);
      @(posedge clk); #1;
    end
    bus_ack = 1'b1;
    @(negedge clk);
    chk("t4_addr_ack", 64'(bus_addr), 64'h01230);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_addr2", 64'(bus_addr), 64'h01231);
    chk("t4_nib2", 64'(bus_data_out), 64'hC);
    chk("t4_done_early", 64'(done), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_done", 64'(done), 64'h1);

    // Async reset after 2 of 5 acked nibbles.
    issue(1'b0, 1'b1, 20'h00500, 64'h0, 4'd0, 4'd4);
    bus_data_in = 4'h9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rd_drop", 64'(bus_rd), 64'h0);
    chk("t5_busy_drop", 64'(busy), 64'h0);
    chk("t5_data_clr", data_o, 64'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_idle_busy", 64'(busy), 64'h0);
    chk("t5_idle_data", data_o, 64'h0);

    // Simultaneous starts: write wins.
    issue(1'b1, 1'b1, 20'h00300, 64'h0000000000A00000, 4'd5, 4'd5);
    @(negedge clk);
    chk("t6a_wr", 64'(bus_wr), 64'h1);
    chk("t6a_rd", 64'(bus_rd), 64'h0);
    chk("t6a_nib", 64'(bus_data_out), 64'hA);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6a_done", 64'(done), 64'h1);

    // Start while busy is ignored.
    issue(1'b1, 1'b0, 20'h00200, 64'h0, 4'd0, 4'd3);
    @(posedge clk); #1;
    start_read = 1'b1; addr = 20'h00999;
    @(posedge clk); #1;
    start_read = 1'b0;
    @(negedge clk);
    chk("t6b_addr", 64'(bus_addr), 64'h00202);
    chk("t6b_wr", 64'(bus_wr), 64'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6b_done", 64'(done), 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6b_no_queue", 64'(busy), 64'h0);

    // Random traffic: random acks, starts at any time, occasional inverted fields and resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      bus_ack     = $urandom_range(0, 3) != 0;
      bus_data_in = 4'($urandom);
      start_write = $urandom_range(0, 7) == 0;
      start_read  = $urandom_range(0, 7) == 0;
      addr        = ($urandom_range(0, 1) == 1) ? 20'(32'hFFFF0 + $urandom_range(0, 15))
                                                : 20'($urandom);
      data_in     = {$urandom, $urandom};
      right_mask  = 4'($urandom);
      left_mask   = 4'($urandom);
      if (left_mask < right_mask && $urandom_range(0, 3) != 0) begin
        logic [3:0] t;
        t = left_mask; left_mask = right_mask; right_mask = t;
      end
      if (cyc % 700 == 350) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    @(posedge clk); #1;
    start_write = 1'b0; start_read = 1'b0;
    repeat (40) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
